// File: rtl/io_input_pkg.sv
// Shared defaults and port bit-slice constants for the switch/key input port.
package io_input_pkg;

  localparam int N_SW_DEF      = 10;
  localparam int TICK_DIV_DEF  = 50000;
  localparam int DB_STABLE_DEF = 4;

  localparam int PORT_W    = 32;
  localparam int PORT_BITS = 5;
  localparam int PORT0_LSB = 0;
  localparam int PORT1_LSB = 5;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_input_port_if.sv
// Board/data-memory side of the switch/key input port.
interface io_input_port_if
  import io_input_pkg::*;
#(
  parameter int N_SW = N_SW_DEF
) ();

  logic [N_SW-1:0]   sw_raw;
  logic              rd_strobe;
  logic [PORT_W-1:0] in_port0;
  logic [PORT_W-1:0] in_port1;
  logic [PORT_W-1:0] edge_flags;
  logic              change_irq;

  modport master (
    output sw_raw, rd_strobe,
    input  in_port0, in_port1, edge_flags, change_irq
  );

  modport slave (
    input  sw_raw, rd_strobe,
    output in_port0, in_port1, edge_flags, change_irq
  );

endinterface

// File: rtl/io_debounce.sv
// One switch bit: two-flop synchronizer followed by a tick-sampled
// consecutive-mismatch counter that qualifies a new stable level.
module io_debounce
  import io_input_pkg::*;
#(
  parameter int DB_STABLE = DB_STABLE_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level
);

  localparam int CW = cnt_width(DB_STABLE);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      // synchronizer stage boundary: raw -> sync_p0 -> sync_p1
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      if (tick) begin
        if (sync_p1 != level) begin
          if (cnt == CW'(DB_STABLE - 1)) begin
            level <= sync_p1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          // any agreeing sample restarts qualification
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/io_input_port.sv
// Debounced switch/key input port with optional sticky change flags and
// interrupt, enabled by defining IO_EDGE_CAPTURE_EN.
module io_input_port
  import io_input_pkg::*;
#(
  parameter int N_SW      = N_SW_DEF,
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int DB_STABLE = DB_STABLE_DEF
) (
  input  logic           clock,
  input  logic           reset,
  io_input_port_if.slave bus
);

  localparam int TW = cnt_width(TICK_DIV);

  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [N_SW-1:0] stable;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_db
    io_debounce #(
      .DB_STABLE (DB_STABLE)
    ) u_db (
      .clock (clock),
      .reset (reset),
      .tick  (tick),
      .raw   (bus.sw_raw[i]),
      .level (stable[i])
    );
  end

  assign bus.in_port0 = PORT_W'(stable[PORT0_LSB +: PORT_BITS]);
  assign bus.in_port1 = PORT_W'(stable[PORT1_LSB +: PORT_BITS]);

`ifdef IO_EDGE_CAPTURE_EN
  logic [N_SW-1:0] stable_prev;
  logic [N_SW-1:0] flags;
  logic [N_SW-1:0] flags_next;
  logic            irq;

  // A fresh change wins over a same-cycle read clear for that bit only.
  always_comb begin
    flags_next = (flags & ~{N_SW{bus.rd_strobe}}) | (stable ^ stable_prev);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_prev <= '0;
      flags       <= '0;
      irq         <= 1'b0;
    end else begin
      stable_prev <= stable;
      flags       <= flags_next;
      irq         <= |flags_next;
    end
  end

  assign bus.edge_flags = PORT_W'(flags);
  assign bus.change_irq = irq;
`else
  logic unused_rd_strobe;

  assign unused_rd_strobe = bus.rd_strobe;
  assign bus.edge_flags   = '0;
  assign bus.change_irq   = 1'b0;
`endif

endmodule

// File: doc/io_input_port.md
IO_INPUT_PORT -- requirements
Module: io_input_port

Interface
REQ-001 Parameter N_SW, default 10, number of raw switch/key inputs; bits [4:0] map to port0 and [9:5] to port1.
REQ-002 Parameter TICK_DIV, default 50000, clock cycles per debounce sample tick (1 ms at 50 MHz).
REQ-003 Parameter DB_STABLE, default 4, consecutive mismatching ticks needed to accept a new level.
REQ-004 The block SHALL have one clock and asynchronous active-high reset: clock and reset.
REQ-005 clock  in  1  system clock, shared with the CPU and data memory.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 sw_raw  in  N_SW  asynchronous switch/key levels from the board pins.
REQ-008 rd_strobe  in  1  single-cycle pulse from the data memory when the CPU reads the edge-status address.
REQ-009 in_port0  out  32  {27'b0, debounced bits [4:0]} to the data memory I/O read mux.
REQ-010 in_port1  out  32  {27'b0, debounced bits [9:5]} to the data memory I/O read mux.
REQ-011 edge_flags  out  32  {22'b0, per-bit change-captured flags}.
REQ-012 change_irq  out  1  OR of all edge flags.

Function
REQ-013 Each sw_raw bit SHALL pass through a two-flop synchronizer before any other use.
REQ-014 The tick counter SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be high for one cycle when the count equals TICK_DIV-1.
REQ-015 Per bit, on tick cycles: if synced != stable, then cnt <= cnt+1; when cnt == DB_STABLE-1, stable <= synced and cnt <= 0.
REQ-016 Per bit, on a tick with synced == stable, cnt SHALL clear to 0 (a glitch restarts qualification).
REQ-017 Between ticks, cnt and stable SHALL hold.
REQ-018 in_port0 and in_port1 SHALL be driven directly from the stable registers; upper bits SHALL be constant 0.
REQ-019 Latency: a clean level change SHALL appear on in_port* 2 sync cycles plus DB_STABLE ticks later, i.e. at most (DB_STABLE+1)*TICK_DIV+2 cycles.
REQ-020 An edge flag bit SHALL set in the cycle after its stable bit changes, in either direction.
REQ-021 rd_strobe SHALL clear all edge flags in the following cycle.
REQ-022 If a flag sets and rd_strobe occurs in the same cycle, set SHALL win for that bit; other bits clear.
REQ-023 Edge flags SHALL be sticky until cleared; repeat edges while set SHALL NOT be counted.
REQ-024 change_irq SHALL be registered, equal to the OR of edge_flags, and not delayed relative to them.

Reset
REQ-025 Reset SHALL clear the synchronizers, tick counter, all cnt, stable, edge_flags and change_irq to 0; in_port0/1 read 0.
REQ-026 Reset asserted mid-qualification SHALL discard partial counts; no edge SHALL be flagged for levels already high at reset release until they are first qualified, which sets their flag once.

Configuration
REQ-027 Macro IO_EDGE_CAPTURE_EN: when defined, REQ-020..REQ-024 are implemented.
REQ-028 When IO_EDGE_CAPTURE_EN is undefined, edge_flags and change_irq SHALL be constant 0, rd_strobe ignored, and no flag registers synthesized.

Structure
REQ-029 Package io_input_pkg SHALL hold N_SW, TICK_DIV, DB_STABLE defaults and the port0/port1 bit-slice constants.
REQ-030 Sub-module io_debounce SHALL implement one bit (sync, cnt, stable) and be instantiated N_SW times sharing one tick.

Verification (bench uses TICK_DIV=4, DB_STABLE=3)
REQ-031 Reset, sw_raw=10'h3FF held -> in_port0=0 until qualified, then 32'h1F and in_port1=32'h1F within 18 cycles; edge_flags=32'h3FF.
REQ-032 sw_raw[2] high for 2 ticks then low -> in_port0 unchanged, no flag.
REQ-033 sw_raw[7] rises cleanly -> in_port1=32'h04 after 3 ticks; edge_flags[7]=1, change_irq=1.
REQ-034 rd_strobe in the same cycle bit 3 sets, with flag 7 pending -> edge_flags=32'h08 afterwards.
REQ-035 Reset asserted with cnt=2 on bit 0 -> all outputs 0 next cycle; after release bit 0 needs a full 3 ticks.
REQ-036 Build without IO_EDGE_CAPTURE_EN, toggle bit 5 -> in_port1 updates, edge_flags=0, change_irq=0.
